// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_sync
// Description : SPI slave running entirely in the system clock domain. SCK, CS
//               and MOSI are oversampled through synchronisers. A FRAME_W-bit
//               word is snapshotted at CS assertion and shifted out MSB first
//               in any SPI mode; MOSI is deserialised into bytes and the frame
//               length is checked when CS rises.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync #(
    parameter int FRAME_W = 40,
    parameter int CPOL    = 0,
    parameter int CPHA    = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [FRAME_W-1:0] i_tx_data,
    input  logic               i_SPI_CLK,
    input  logic               i_SPI_CS,
    input  logic               i_SPI_MOSI,
    output logic               o_SPI_MISO,
    output logic               o_miso_oe,
    output logic               o_tx_latched,
    output logic [7:0]         o_rx_byte,
    output logic               o_rx_valid,
    output logic               o_frame_done,
    output logic               o_frame_err
);

    localparam int                 c_CNT_W    = $clog2(FRAME_W + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_DONE = c_CNT_W'(FRAME_W);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(FRAME_W + 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // [0],[1] are the synchroniser flops, [2] is the edge-detect history stage
    logic [2:0] r_sck_pipe;
    logic [2:0] r_cs_pipe;
    logic [1:0] r_mosi_pipe;

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_sck_lead;
    logic w_sck_trail;
    logic w_sample;
    logic w_drive;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_drive_ok;

    // Registered strobes; MOSI is captured alongside so it stays aligned
    logic r_sample_stb;
    logic r_drive_stb;
    logic r_cs_rise_stb;
    logic r_mosi_smp;

    logic [FRAME_W-1:0] r_tx_sr;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [2:0]         r_byte_cnt;
    logic [7:0]         r_rx_sr;
    logic [7:0]         r_rx_byte;
    logic               r_rx_valid;
    logic               r_miso;
    logic               r_miso_oe;
    logic               r_frame_done;
    logic               r_frame_err;

    // Synchronise the asynchronous SPI pins and keep one history stage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sck_pipe  <= 3'b000;
            r_cs_pipe   <= 3'b000;
            r_mosi_pipe <= 2'b00;
        end else begin
            r_sck_pipe  <= {r_sck_pipe[1:0], i_SPI_CLK};
            r_cs_pipe   <= {r_cs_pipe[1:0], i_SPI_CS};
            r_mosi_pipe <= {r_mosi_pipe[0], i_SPI_MOSI};
        end
    end

    assign w_sck_rise  = r_sck_pipe[1] & ~r_sck_pipe[2];
    assign w_sck_fall  = ~r_sck_pipe[1] & r_sck_pipe[2];
    assign w_sck_lead  = (CPOL == 0) ? w_sck_rise : w_sck_fall;
    assign w_sck_trail = (CPOL == 0) ? w_sck_fall : w_sck_rise;
    assign w_sample    = (CPHA == 0) ? w_sck_lead : w_sck_trail;
    assign w_drive     = (CPHA == 0) ? w_sck_trail : w_sck_lead;
    assign w_cs_fall   = ~r_cs_pipe[1] & r_cs_pipe[2];
    assign w_cs_rise   = r_cs_pipe[1] & ~r_cs_pipe[2];

    // In CPHA=0 the first bit is presented at LOAD, so a drive edge seen
    // before any sample edge must not advance the shifter
    assign w_drive_ok  = (CPHA != 0) || (r_bit_cnt != '0);

    // Register the mode-resolved edge strobes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sample_stb  <= 1'b0;
            r_drive_stb   <= 1'b0;
            r_cs_rise_stb <= 1'b0;
            r_mosi_smp    <= 1'b0;
        end else begin
            r_sample_stb  <= w_sample;
            r_drive_stb   <= w_drive;
            r_cs_rise_stb <= w_cs_rise;
            r_mosi_smp    <= r_mosi_pipe[1];
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; WAIT guards against a frame already in progress
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT:  if (r_cs_pipe[1])  w_state_nxt = ST_IDLE;
            ST_IDLE:  if (w_cs_fall)     w_state_nxt = ST_LOAD;
            ST_LOAD:                     w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cs_rise_stb) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_WAIT;
        endcase
    end

    // Frame datapath: TX snapshot/shift, RX deserialiser, frame-length check
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_sr      <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= 3'd0;
            r_rx_sr      <= 8'h00;
            r_rx_byte    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= 3'd0;
                    r_rx_sr    <= 8'h00;
                    r_miso_oe  <= 1'b1;
                    if (CPHA == 0) begin
                        r_miso  <= i_tx_data[FRAME_W-1];
                        r_tx_sr <= {i_tx_data[FRAME_W-2:0], 1'b0};
                    end else begin
                        r_miso  <= 1'b0;
                        r_tx_sr <= i_tx_data;
                    end
                end
                ST_SHIFT: begin
                    if (r_cs_rise_stb) begin
                        r_frame_done <= (r_bit_cnt == c_CNT_DONE);
                        r_frame_err  <= (r_bit_cnt != c_CNT_DONE);
                        r_miso_oe    <= 1'b0;
                        r_miso       <= 1'b0;
                    end else if (r_sample_stb) begin
                        r_rx_sr    <= {r_rx_sr[6:0], r_mosi_smp};
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        if (r_bit_cnt != c_CNT_SAT) begin
                            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        end
                        if (r_byte_cnt == 3'd7) begin
                            r_rx_byte  <= {r_rx_sr[6:0], r_mosi_smp};
                            r_rx_valid <= 1'b1;
                        end
                    end else if (r_drive_stb && w_drive_ok) begin
                        // Zero fill makes MISO read 0 once every bit is out
                        r_miso  <= r_tx_sr[FRAME_W-1];
                        r_tx_sr <= {r_tx_sr[FRAME_W-2:0], 1'b0};
                    end
                end
                default: begin
                    r_miso_oe <= 1'b0;
                    r_miso    <= 1'b0;
                end
            endcase
        end
    end

    assign o_SPI_MISO   = r_miso;
    assign o_miso_oe    = r_miso_oe;
    assign o_tx_latched = (r_state == ST_LOAD);
    assign o_rx_byte    = r_rx_byte;
    assign o_rx_valid   = r_rx_valid;
    assign o_frame_done = r_frame_done;
    assign o_frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_sync
// Description : Self-checking bench; one instance per SPI mode driven by a
//               common master, checked against a behavioural frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_sync;

    localparam int FW = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          sck_raw;
    logic          mosi0;
    logic          mosi1;
    logic [FW-1:0] tx;

    logic [3:0] miso, oe, txl, rxv, done, err;
    logic [7:0] rxb [4];

    int checks = 0;
    int errors = 0;

    int          rx_cnt   [4] = '{default: 0};
    int          done_cnt [4] = '{default: 0};
    int          err_cnt  [4] = '{default: 0};
    int          txl_cnt  [4] = '{default: 0};
    logic [63:0] rx_hist  [4] = '{default: '0};

    always #5 clk = ~clk;

    // Instance g runs mode g: CPOL = g/2, CPHA = g%2. The raw master clock is
    // inverted for CPOL=1 so that leading edges coincide for every instance.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LP_CPOL = g / 2;
        localparam int LP_CPHA = g % 2;
        logic sck_g;
        logic mosi_g;
        assign sck_g  = sck_raw ^ (LP_CPOL != 0);
        assign mosi_g = (LP_CPHA != 0) ? mosi1 : mosi0;
        spi_slave_sync #(
            .FRAME_W (FW),
            .CPOL    (LP_CPOL),
            .CPHA    (LP_CPHA)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_tx_data    (tx),
            .i_SPI_CLK    (sck_g),
            .i_SPI_CS     (cs),
            .i_SPI_MOSI   (mosi_g),
            .o_SPI_MISO   (miso[g]),
            .o_miso_oe    (oe[g]),
            .o_tx_latched (txl[g]),
            .o_rx_byte    (rxb[g]),
            .o_rx_valid   (rxv[g]),
            .o_frame_done (done[g]),
            .o_frame_err  (err[g])
        );
    end

    // Pulse monitor: counts pulses and records received bytes
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rxv[i]) begin
                rx_cnt[i]  <= rx_cnt[i] + 1;
                rx_hist[i] <= {rx_hist[i][55:0], rxb[i]};
            end
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (err[i])  err_cnt[i]  <= err_cnt[i] + 1;
            if (txl[i])  txl_cnt[i]  <= txl_cnt[i] + 1;
        end
    end

    // One master frame of nbits SCK cycles; MOSI bit k is mosi_pat[63-k].
    task automatic run_frame(input logic [FW-1:0] tx_val, input logic [63:0] mosi_pat,
                             input int nbits, input bit change_tx, input int abort_bit,
                             input string name);
        int          rx0 [4];
        int          dn0 [4];
        int          er0 [4];
        int          tl0 [4];
        logic [63:0] cap [4];
        logic [63:0] exp_cap;
        logic [63:0] exp_hist;
        logic [63:0] mask;
        int          nbytes;
        int          c;
        bit          aborted;
        for (int i = 0; i < 4; i++) begin
            rx0[i] = rx_cnt[i];
            dn0[i] = done_cnt[i];
            er0[i] = err_cnt[i];
            tl0[i] = txl_cnt[i];
            cap[i] = '0;
        end
        tx = tx_val;
        @(negedge clk);
        cs = 1'b0;
        if (change_tx) begin
            c = 0;
            while (!txl[0] && c < 20) begin
                @(negedge clk);
                c++;
            end
            checks++;
            if (txl[0] !== 1'b1) begin
                errors++;
                $display("FAIL %s tx_latched_seen got %b want 1", name, txl[0]);
            end
            repeat (2) @(negedge clk);
            tx = '0;
        end else begin
            repeat (5) @(negedge clk);
        end
        aborted = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            if (k == abort_bit) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({miso, oe, txl, rxv, done, err, rxb[0], rxb[1], rxb[2], rxb[3]} !== '0) begin
                    errors++;
                    $display("FAIL %s reset_midframe_outputs got miso=%b oe=%b txl=%b rxv=%b done=%b err=%b want all 0",
                             name, miso, oe, txl, rxv, done, err);
                end
                repeat (3) @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            repeat (2) @(negedge clk);
            mosi0 = mosi_pat[63-k];
            repeat (3) @(negedge clk);
            cap[0] = {cap[0][62:0], miso[0]};
            cap[2] = {cap[2][62:0], miso[2]};
            sck_raw = 1'b1;
            repeat (2) @(negedge clk);
            mosi1 = mosi_pat[63-k];
            repeat (3) @(negedge clk);
            cap[1] = {cap[1][62:0], miso[1]};
            cap[3] = {cap[3][62:0], miso[3]};
            sck_raw = 1'b0;
        end
        repeat (6) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);

        if (aborted) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ((done_cnt[i] - dn0[i]) !== 0 || (err_cnt[i] - er0[i]) !== 0) begin
                    errors++;
                    $display("FAIL %s mode%0d aborted_no_pulse got done=%0d err=%0d want 0 0",
                             name, i, done_cnt[i] - dn0[i], err_cnt[i] - er0[i]);
                end
                checks++;
                if (oe[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s mode%0d oe_after got %b want 0", name, i, oe[i]);
                end
            end
        end else begin
            // Model: TX bits MSB first then zeros; whole MOSI bytes only
            exp_cap = '0;
            for (int k = 0; k < nbits; k++) begin
                exp_cap = {exp_cap[62:0], (k < FW) ? tx_val[FW-1-k] : 1'b0};
            end
            nbytes   = nbits / 8;
            exp_hist = '0;
            for (int b = 0; b < nbytes; b++) begin
                exp_hist = {exp_hist[55:0], mosi_pat[63-8*b -: 8]};
            end
            mask = (nbytes >= 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cap[i] !== exp_cap) begin
                    errors++;
                    $display("FAIL %s mode%0d miso_bits got %h want %h", name, i, cap[i], exp_cap);
                end
                checks++;
                if ((rx_cnt[i] - rx0[i]) !== nbytes) begin
                    errors++;
                    $display("FAIL %s mode%0d rx_valid_count got %0d want %0d",
                             name, i, rx_cnt[i] - rx0[i], nbytes);
                end
                checks++;
                if ((rx_hist[i] & mask) !== exp_hist) begin
                    errors++;
                    $display("FAIL %s mode%0d rx_bytes got %h want %h",
                             name, i, rx_hist[i] & mask, exp_hist);
                end
                checks++;
                if ((done_cnt[i] - dn0[i]) !== ((nbits == FW) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL %s mode%0d frame_done_count got %0d want %0d",
                             name, i, done_cnt[i] - dn0[i], (nbits == FW) ? 1 : 0);
                end
                checks++;
                if ((err_cnt[i] - er0[i]) !== ((nbits != FW) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL %s mode%0d frame_err_count got %0d want %0d",
                             name, i, err_cnt[i] - er0[i], (nbits != FW) ? 1 : 0);
                end
                checks++;
                if ((txl_cnt[i] - tl0[i]) !== 1) begin
                    errors++;
                    $display("FAIL %s mode%0d tx_latched_count got %0d want 1",
                             name, i, txl_cnt[i] - tl0[i]);
                end
                checks++;
                if (oe[i] !== 1'b0 || miso[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s mode%0d idle_outputs got oe=%b miso=%b want 0 0",
                             name, i, oe[i], miso[i]);
                end
            end
        end
    endtask

    function automatic logic [FW-1:0] rand_tx();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[FW-1:0];
    endfunction

    function automatic logic [63:0] rand_pat();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({miso[i], oe[i], txl[i], rxv[i], done[i], err[i], rxb[i]} !== 14'h0) begin
                errors++;
                $display("FAIL reset mode%0d outputs got miso=%b oe=%b txl=%b rxv=%b done=%b err=%b rxb=%h want 0",
                         i, miso[i], oe[i], txl[i], rxv[i], done[i], err[i], rxb[i]);
            end
        end
    endtask

    task automatic test_all_modes_fixed();
        run_frame(40'hA5_1234_5678, {8{8'h3C}}, FW, 1'b0, -1, "fixed");
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 3; n++) begin
            run_frame(rand_tx(), rand_pat(), FW, 1'b0, -1, "random");
        end
    endtask

    task automatic test_tx_change();
        run_frame(40'hA5_1234_5678, rand_pat(), FW, 1'b1, -1, "tx_change");
    endtask

    task automatic test_short_frame();
        run_frame(rand_tx(), rand_pat(), 12, 1'b0, -1, "short");
    endtask

    task automatic test_long_frame();
        run_frame(rand_tx(), rand_pat(), 48, 1'b0, -1, "long");
    endtask

    task automatic test_reset_midframe();
        run_frame(rand_tx(), rand_pat(), FW, 1'b0, 20, "abort");
        run_frame(40'hA5_1234_5678, rand_pat(), FW, 1'b0, -1, "after_abort");
    endtask

    initial begin
        rst     = 1'b1;
        cs      = 1'b1;
        sck_raw = 1'b0;
        mosi0   = 1'b0;
        mosi1   = 1'b0;
        tx      = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        test_all_modes_fixed();
        test_random_frames();
        test_tx_change();
        test_short_frame();
        test_long_frame();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_sync.md
# spi_slave_sync

Parametrised SPI slave for the freqMes readout path, running entirely in the system clock domain. SCK, CS and MOSI are oversampled through synchronisers, so no logic is clocked by SCK. The block snapshots a FRAME_W-bit measurement word atomically at chip-select assertion and shifts it out in any of the four SPI modes. It also deserialises MOSI into bytes and flags frames that end early or run long.

## Interface
- FRAME_W, 40: bits in one TX frame (8..256).
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, drive on trailing; 1 = drive on leading, sample on trailing.
- i_clk  in  1  system clock; must be ≥ 8× SCK frequency.
- i_rst  in  1  reset, asynchronous, active-high.
- i_tx_data  in  FRAME_W  word to transmit, MSB first; sampled only at frame start.
- i_SPI_CLK  in  1  SPI clock, asynchronous.
- i_SPI_CS  in  1  chip select, active-low, asynchronous.
- i_SPI_MOSI  in  1  master data, asynchronous.
- o_SPI_MISO  out  1  slave data.
- o_miso_oe  out  1  MISO drive enable; high while the frame is active.
- o_tx_latched  out  1  1-cycle pulse when i_tx_data is captured.
- o_rx_byte  out  8  last complete received byte, MSB first.
- o_rx_valid  out  1  1-cycle pulse when o_rx_byte is updated.
- o_frame_done  out  1  1-cycle pulse when CS rises after exactly FRAME_W SCK sample edges.
- o_frame_err  out  1  1-cycle pulse when CS rises after any other edge count (short or long frame).

## Operation
- Synchronisers: SCK, CS and MOSI each pass through 2 flops, followed by one registered stage for edge detection.
- Leading edge is rising when CPOL=0 and falling when CPOL=1. The trailing edge is the opposite.
- State machine, with WAIT as the reset state:
  - WAIT: stays here until synchronised CS = 1, then goes to IDLE. This prevents a false frame when reset releases mid-transfer.
  - IDLE: on the CS falling edge, goes to LOAD.
  - LOAD (1 cycle):
    - Latch i_tx_data into the shift register and pulse o_tx_latched.
    - Clear the bit counter and the RX shift register.
    - Set o_miso_oe = 1.
    - If CPHA=0, drive o_SPI_MISO with bit FRAME_W-1.
    - Go to SHIFT.
  - SHIFT, sample edge:
    - Shift MOSI into the RX register and increment the bit counter. The counter saturates at FRAME_W+1 and is clog2(FRAME_W+2) bits wide.
    - Every 8th sample, update o_rx_byte and pulse o_rx_valid. The byte counter wraps 7→0 and RX continues past FRAME_W.
  - SHIFT, drive edge: present the next TX bit on o_SPI_MISO.
    - CPHA=0: skip the drive edge that precedes the first sample edge.
    - After all FRAME_W bits have been presented, o_SPI_MISO = 0.
  - SHIFT, CS rising edge (takes priority over a coincident SCK edge):
    - Pulse o_frame_done if counter == FRAME_W, otherwise pulse o_frame_err.
    - Clear o_miso_oe and o_SPI_MISO, then go to IDLE.
    - A partial RX byte is discarded; no o_rx_valid is generated for it.
- i_tx_data changes after LOAD do not affect the current frame.

## Timing
- Reset values: o_SPI_MISO=0, o_miso_oe=0, o_tx_latched=0, o_rx_byte=8'h00, o_rx_valid=0, o_frame_done=0, o_frame_err=0. All internal registers are cleared and the state is WAIT.
- Latency from a pin edge to the internal edge strobe: 3 i_clk cycles.
- CS fall pin → o_tx_latched: 3 cycles. MISO is valid one cycle after that (4 cycles). The master must allow ≥ 5 i_clk cycles between CS fall and the first SCK edge.
- Drive edge pin → new o_SPI_MISO: 4 cycles. This is within half an SCK period when i_clk ≥ 8× SCK.
- 8th sample edge pin → o_rx_valid: 4 cycles.
- CS rise pin → o_frame_done / o_frame_err: 4 cycles.
- All pulses are exactly one i_clk cycle wide.
- Minimum CS-high time between frames: 4 i_clk cycles.
- Reset asserted mid-frame: outputs return to reset values immediately. After release the block waits in WAIT for CS high, and neither o_frame_done nor o_frame_err is produced for the aborted frame.

## Test plan
- Mode 0, FRAME_W=40, i_tx_data=40'hA5_1234_5678, with 40 SCK cycles at clk/10 and MOSI=8'h3C repeated:
  - MISO bits captured by the master equal A512345678.
  - Five o_rx_valid pulses, each with o_rx_byte=8'h3C.
  - One o_frame_done pulse.
- Modes 1, 2 and 3, same stimulus as above: identical captured data and pulses in each mode.
- i_tx_data changed to 40'h0 two cycles after o_tx_latched: the full frame still reads A512345678.
- Short frame of 12 SCK cycles, then CS high:
  - One o_rx_valid pulse.
  - o_frame_err pulses, o_frame_done stays 0.
  - o_miso_oe returns to 0.
- Long frame of 48 SCK cycles: MISO reads 0 for bits 41-48, o_rx_valid pulses 6 times, and o_frame_err pulses.
- i_rst asserted during bit 20 while CS stays low, then CS rises and a normal frame follows:
  - No done/err pulse for the aborted frame.
  - The following frame completes with o_frame_done.
